spi_led_blink_multi: RTL
========================

// Module: spi_led_blink_multi
// PURPOSE
//  Multi-channel LED driver controlled by byte commands from the SPI slave receiver.
//  Each channel has its own mode (off/on/blink/one-shot) and its own half-period.
//  Sits between spi_slave (rx byte + done strobe) and the board LED pins.
//  Two-byte command frames carry a timeout; bad frames raise an error strobe.
// PARAMETERS
//  NUM_CH        4          number of LED channels (1..16)
//  CNT_W         32         per-channel counter / half-period width
//  PERIOD_SHIFT  24         half_period = {period_byte, PERIOD_SHIFT zeros}; 8+PERIOD_SHIFT <= CNT_W
//  TIMEOUT_CYC   5_000_000  max cycles between header byte and data byte (100 ms at 50 MHz)
// PORTS
//  clk              in   1       system clock, 50 MHz
//  rst_n            in   1       asynchronous reset, active-low
//  o_spi_s_rx_done  in   1       one-cycle strobe: r_spi_s_rx_data is valid
//  r_spi_s_rx_data  in   8       received SPI byte
//  led              out  NUM_CH  LED pin levels
//  led_en           out  NUM_CH  LED pin output enables
//  clk_en           out  1       clock input enable, tied 1
//  cmd_busy         out  1       1 while a header is accepted and its data byte is pending
//  cmd_err          out  1       one-cycle pulse on a rejected byte/frame
// BEHAVIOUR
//  Reset (async assert, sync release): led=0, led_en=all 1, cmd_busy=0, cmd_err=0;
//   every channel mode=OFF, period_byte=8'h01, counter=0; FSM=IDLE.
//  Frame: byte0 header {1, mode[1:0], 1'b0, ch[3:0]}; byte1 period byte (any value).
//   mode: 00 OFF, 01 ON, 10 BLINK, 11 ONESHOT.
//  FSM IDLE: rx_done & bit7=1 & ch<NUM_CH -> latch mode/ch, WAIT_DATA, cmd_busy=1.
//   rx_done & bit7=0 -> byte dropped, cmd_err pulse next cycle, stay IDLE.
//   rx_done & ch>=NUM_CH -> header dropped, cmd_err pulse, stay IDLE.
//  FSM WAIT_DATA: rx_done -> apply to channel ch, back to IDLE, cmd_busy=0.
//   Timeout counter counts cycles in WAIT_DATA; at TIMEOUT_CYC with no byte ->
//   frame discarded, cmd_err pulse, IDLE. Byte arriving on the timeout cycle wins (applied).
//  Apply (clock edge ending the data-byte cycle): mode/period_byte written, channel
//   counter cleared to 0, led[ch] forced: OFF->0, ON->1, BLINK->0, ONESHOT->1.
//   New led level visible 1 cycle after rx_done. Other channels undisturbed.
//  half_period = max(period_byte,1) << PERIOD_SHIFT (period_byte 0 treated as 1).
//  BLINK: counter increments each cycle; when counter >= half_period-1 -> counter=0,
//   led toggles. Full period = 2*half_period cycles. ">=" means a shrunk period
//   never causes counter wrap; counter never exceeds half_period-1 in steady state.
//  ONESHOT: led=1 for exactly half_period cycles, then led=0, mode becomes OFF.
//  OFF/ON: counter held at 0.
//  A new frame to a running channel restarts it (counter reset, phase reset).
//  rx_done only sampled as a single-cycle strobe; back-to-back strobes legal.
//  rst_n asserted mid-frame or mid-blink: all state returns to reset values immediately.
//  cmd_err: registered, 1 cycle wide, 1 cycle after the causing event.
// TESTING (NUM_CH=4, PERIOD_SHIFT=2, TIMEOUT_CYC=20)
//  1 Reset release, no bytes -> led=4'b0000, led_en=4'b1111, cmd_busy=0 for 100 cycles.
//  2 Bytes 8'hC1, 8'h03 -> led[1]=0, toggles every 12 cycles (period 24); others stay 0.
//  3 Bytes 8'hA2, 8'h00 -> led[2]=1 from next cycle, stays 1; then 8'h82,8'h00 -> led[2]=0.
//  4 Bytes 8'hE3, 8'h02 -> led[3]=1 for exactly 8 cycles then 0 and stays 0.
//  5 Header 8'hC0, no data for 20 cycles -> cmd_err one pulse, cmd_busy drops, ch0 unchanged;
//    header 8'hC5 -> cmd_err pulse, no state change; byte 8'h13 in IDLE -> cmd_err pulse.
//  6 Ch0 blinking 8'hFF, mid-count reprogram to 8'h01 -> next toggle within 4 cycles;
//    rst_n low mid-frame -> all outputs at reset values, following frame decoded normally.

Source files
------------

// File: rtl/spi_led_blink_multi.sv
// Multi-channel LED driver decoding two-byte SPI command frames (header + period byte).
// Latency: a frame takes effect on the edge that samples its data byte; LED level moves one cycle after that strobe.
// No backpressure: bytes arrive as one-cycle strobes; bad bytes, frames and timeouts raise a registered cmd_err pulse.
module spi_led_blink_multi #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 32,
   parameter int PERIOD_SHIFT = 24,
   parameter int TIMEOUT_CYC  = 5_000_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              o_spi_s_rx_done,
   input  logic [7:0]        r_spi_s_rx_data,
   output logic [NUM_CH-1:0] led,
   output logic [NUM_CH-1:0] led_en,
   output logic              clk_en,
   output logic              cmd_busy,
   output logic              cmd_err
);

   // Timeout counter only needs to reach TIMEOUT_CYC-1 before it fires.
   localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_ONESHOT = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_WAIT_DATA = 1'b1
   } state_e;

   state_e           state, state_nxt;
   mode_e            mode_lat;
   logic [3:0]       ch_lat;
   logic [TMO_W-1:0] tmo_cnt;
   logic             err_nxt;
   logic             latch_hdr;
   logic             apply_stb;
   logic             ch_ok;

   // Pins are always driven; the clock input is always enabled.
   assign led_en   = '1;
   assign clk_en   = 1'b1;
   assign cmd_busy = (state == ST_WAIT_DATA);

   // Header channel field must address an existing channel.
   assign ch_ok = ({28'd0, r_spi_s_rx_data[3:0]} < 32'(NUM_CH));

   // Frame decoder: header acceptance/rejection, data apply and timeout.
   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      latch_hdr = 1'b0;
      apply_stb = 1'b0;
      case (state)
         ST_IDLE: begin
            if (o_spi_s_rx_done) begin
               if (!r_spi_s_rx_data[7] || !ch_ok) begin
                  err_nxt = 1'b1;
               end else begin
                  latch_hdr = 1'b1;
                  state_nxt = ST_WAIT_DATA;
               end
            end
         end
         ST_WAIT_DATA: begin
            // A byte on the timeout cycle still completes the frame.
            if (o_spi_s_rx_done) begin
               apply_stb = 1'b1;
               state_nxt = ST_IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state register and registered error strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cmd_err <= 1'b0;
      end else begin
         state   <= state_nxt;
         cmd_err <= err_nxt;
      end
   end

   // Cycles spent waiting for the data byte; cleared whenever the wait ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state == ST_WAIT_DATA && state_nxt == ST_WAIT_DATA) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
         tmo_cnt <= '0;
      end
   end

   // Header fields held until the data byte arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_lat <= MODE_OFF;
         ch_lat   <= 4'd0;
      end else if (latch_hdr) begin
         mode_lat <= mode_e'(r_spi_s_rx_data[6:5]);
         ch_lat   <= r_spi_s_rx_data[3:0];
      end
   end

   // Per-channel pattern engines.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mode_e            ch_mode;
      logic [7:0]       ch_pb;
      logic [7:0]       pb_nz;
      logic [CNT_W-1:0] ch_cnt;
      logic [CNT_W-1:0] hp_m1;
      logic             ch_led;
      logic             ch_apply;
      logic             cnt_end;

      assign ch_apply = apply_stb && (ch_lat == 4'(i));
      // Period byte 0 behaves like 1 so the half period is never zero.
      assign pb_nz    = (ch_pb == 8'd0) ? 8'd1 : ch_pb;
      assign hp_m1    = (CNT_W'(pb_nz) << PERIOD_SHIFT) - CNT_W'(1);
      // ">=" lets a freshly shortened period end immediately instead of wrapping.
      assign cnt_end  = (ch_cnt >= hp_m1);
      assign led[i]   = ch_led;

      // Apply a new frame (restarting phase) or advance the running pattern.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ch_mode <= MODE_OFF;
            ch_pb   <= 8'h01;
            ch_cnt  <= '0;
            ch_led  <= 1'b0;
         end else if (ch_apply) begin
            ch_mode <= mode_lat;
            ch_pb   <= r_spi_s_rx_data;
            ch_cnt  <= '0;
            ch_led  <= (mode_lat == MODE_ON) || (mode_lat == MODE_ONESHOT);
         end else begin
            case (ch_mode)
               MODE_BLINK: begin
                  if (cnt_end) begin
                     ch_cnt <= '0;
                     ch_led <= ~ch_led;
                  end else begin
                     ch_cnt <= ch_cnt + CNT_W'(1);
                  end
               end
               MODE_ONESHOT: begin
                  if (cnt_end) begin
                     ch_cnt  <= '0;
                     ch_led  <= 1'b0;
                     ch_mode <= MODE_OFF;
                  end else begin
                     ch_cnt <= ch_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  ch_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule
